apb_emu: RTL and testbench

APB_EMU -- requirements
Module: apb_emu

---
 rtl/apb_emu_pkg.sv | 58 +++++
 rtl/apb_emu.sv | 176 +++++++++++++++++
 tb/tb_apb_emu.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_emu_pkg.sv
// apb_emu_pkg -- shared types and constants for the APB4 command emulator.
//
// Contents:
//   MAX_CMDS / CMD_IDX_W : capacity of the command table and its index width
//   cmd_t                : one command entry (write flag, addr, data, strb, compare mask)
//   cmd_table_t          : packed table of MAX_CMDS entries, entry 0 in the low bits
//   state_t              : sequencer FSM states
//   make_cmd()           : builds one entry; used to assemble constant tables
//   DEFAULT_CMD_TABLE    : table used when the instantiator does not supply one
//
// Optional feature macro used by apb_emu: APB_EMU_TIMEOUT_EN.
package apb_emu_pkg;

    localparam int MAX_CMDS  = 8;
    localparam int CMD_IDX_W = $clog2(MAX_CMDS);

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;  // write data, or expected read data
        logic [3:0]  strb;
        logic [31:0] mask;  // read compare mask; 0 disables the check
    } cmd_t;

    typedef cmd_t [MAX_CMDS-1:0] cmd_table_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic cmd_t make_cmd(input logic        write,
                                      input logic [31:0] addr,
                                      input logic [31:0] data,
                                      input logic [3:0]  strb,
                                      input logic [31:0] mask);
        cmd_t c;
        c.write = write;
        c.addr  = addr;
        c.data  = data;
        c.strb  = strb;
        c.mask  = mask;
        return c;
    endfunction

    // Unused tail entries are zero; only the first NUM_CMDS entries are executed.
    localparam cmd_table_t DEFAULT_CMD_TABLE = {
        {((MAX_CMDS - 4) * $bits(cmd_t)){1'b0}},
        make_cmd(1'b0, 32'h0000_0048, 32'h1234_0000, 4'b0101, 32'hFFFF_FFFF),
        make_cmd(1'b0, 32'h0000_0040, 32'h1234_0000, 4'b1111, 32'hFFFF_0000),
        make_cmd(1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'b0011, 32'h0000_0000),
        make_cmd(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000)
    };

endpackage

// File: rtl/apb_emu.sv
// apb_emu -- APB4 master that replays a constant command table once after reset.
//
// Parameters:
//   NUM_CMDS       : entries executed from CMD_TABLE (0..MAX_CMDS)
//   GAP_CYCLES     : idle bus cycles between transfers (0 = back-to-back)
//   TIMEOUT_CYCLES : ACCESS cycles with ready low before abort (APB_EMU_TIMEOUT_EN only)
//   CMD_TABLE      : command table, entry 0 executed first
//
// Ports:
//   apb_clk_i, apb_reset_i : clock, synchronous active-high reset
//   apb_clk_en_o           : bus clock request (SETUP, ACCESS, GAP)
//   apb_addr_o .. apb_wdata_o : APB4 request; zero outside SETUP/ACCESS
//   apb_ready_i, apb_rdata_i, apb_slverr_i : APB4 completer response
//   emulator_id_i          : address offset, sampled when each SETUP is entered
//   done_o                 : sequence finished (terminal until reset)
//   error_o                : sticky; slverr, read-compare miss or timeout abort
//
// Handshake: a transfer completes in an ACCESS cycle where apb_ready_i is
// sampled high; sel/enable and the request fields stay constant until then.
//
// Build option: define APB_EMU_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES consecutive ready-low cycles (flagged in error_o).
module apb_emu
    import apb_emu_pkg::*;
#(
    parameter int         NUM_CMDS       = 4,
    parameter int         GAP_CYCLES     = 1,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter cmd_table_t CMD_TABLE      = DEFAULT_CMD_TABLE
) (
    input  logic        apb_clk_i,
    input  logic        apb_reset_i,
    output logic        apb_clk_en_o,
    output logic [31:0] apb_addr_o,
    output logic        apb_sel_o,
    output logic        apb_enable_o,
    output logic        apb_write_o,
    output logic [3:0]  apb_strb_o,
    output logic [2:0]  apb_prot_o,
    output logic [31:0] apb_wdata_o,
    input  logic        apb_ready_i,
    input  logic [31:0] apb_rdata_i,
    input  logic        apb_slverr_i,
    input  logic [31:0] emulator_id_i,
    output logic        done_o,
    output logic        error_o
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (NUM_CMDS < 0 || NUM_CMDS > MAX_CMDS || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_emu: need 0 <= NUM_CMDS <= MAX_CMDS, GAP_CYCLES >= 0, TIMEOUT_CYCLES >= 1");
    end

    state_t                 state_q, state_d;
    logic [CMD_IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [31:0]            addr_q, addr_d;
    logic                   error_q, error_d;

    logic                   cur_write;
    logic                   is_last;
    logic                   read_miss;
    logic                   timeout_hit;
    logic                   in_xfer;

    assign cur_write = CMD_TABLE[idx_q].write;
    assign is_last   = (idx_q == CMD_IDX_W'(NUM_CMDS - 1));
    // Only the masked bits take part in the compare.
    assign read_miss = !cur_write &&
                       (((apb_rdata_i ^ CMD_TABLE[idx_q].data) & CMD_TABLE[idx_q].mask) != 32'd0);

`ifdef APB_EMU_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // to_cnt_q counts ACCESS cycles already spent; the TIMEOUT_CYCLES-th
    // consecutive ready-low cycle is the aborting one.
    assign timeout_hit = (state_q == ST_ACCESS) && !apb_ready_i &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign to_cnt_d    = (state_q == ST_ACCESS) ? to_cnt_q + 1'b1 : '0;

    always_ff @(posedge apb_clk_i) begin
        if (apb_reset_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        addr_d  = addr_q;
        error_d = error_q;

        case (state_q)
            ST_IDLE: begin
                state_d = (NUM_CMDS == 0) ? ST_DONE : ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb_ready_i || timeout_hit) begin
                    if (timeout_hit || apb_slverr_i || read_miss) begin
                        error_d = 1'b1;
                    end
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_SETUP;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_SETUP;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The offset is captured on every SETUP entry so the address stays
        // stable for the whole transfer even if emulator_id_i moves.
        if (state_d == ST_SETUP && state_q != ST_SETUP) begin
            addr_d = CMD_TABLE[idx_d].addr + emulator_id_i;
        end
    end

    always_ff @(posedge apb_clk_i) begin
        if (apb_reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            addr_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            addr_q  <= addr_d;
            error_q <= error_d;
        end
    end

    assign in_xfer      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign apb_sel_o    = in_xfer;
    assign apb_enable_o = (state_q == ST_ACCESS);
    assign apb_addr_o   = in_xfer ? addr_q : 32'd0;
    assign apb_write_o  = in_xfer && cur_write;
    assign apb_strb_o   = (in_xfer && cur_write) ? CMD_TABLE[idx_q].strb : 4'd0;
    assign apb_wdata_o  = (in_xfer && cur_write) ? CMD_TABLE[idx_q].data : 32'd0;
    assign apb_prot_o   = 3'b000;
    assign apb_clk_en_o = in_xfer || (state_q == ST_GAP);
    assign done_o       = (state_q == ST_DONE);
    assign error_o      = error_q;

endmodule

// File: tb/tb_apb_emu.sv
// tb_apb_emu -- self-checking bench for apb_emu.
// A reactive completer answers each transfer after a configured number of
// wait cycles; a reference model computes expected addresses, data, access
// lengths, gap lengths, done timing and the error flag from the table.
// Timeout checks follow APB_EMU_TIMEOUT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_apb_emu;
    import apb_emu_pkg::*;

    localparam int N   = 4;
    localparam int GAP = 1;
    localparam int TMO = 16;

    localparam cmd_table_t TBL = {
        {((MAX_CMDS - N) * $bits(cmd_t)){1'b0}},
        make_cmd(1'b0, 32'h0000_0048, 32'h1234_0000, 4'b0101, 32'hFFFF_FFFF),
        make_cmd(1'b0, 32'h0000_0040, 32'h1234_0000, 4'b1111, 32'hFFFF_0000),
        make_cmd(1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'b0011, 32'h0000_0000),
        make_cmd(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000)
    };

    // ---------------- clock / reset / DUT ----------------
    logic        apb_clk_i = 1'b0;
    logic        apb_reset_i = 1'b1;
    logic        apb_ready_i = 1'b0;
    logic [31:0] apb_rdata_i = 32'd0;
    logic        apb_slverr_i = 1'b0;
    logic [31:0] emulator_id_i = 32'd0;
    logic        apb_clk_en_o, apb_sel_o, apb_enable_o, apb_write_o, done_o, error_o;
    logic [31:0] apb_addr_o, apb_wdata_o;
    logic [3:0]  apb_strb_o;
    logic [2:0]  apb_prot_o;
    logic [76:0] all_out;

    always #5 apb_clk_i = ~apb_clk_i;

    apb_emu #(
        .NUM_CMDS(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CMD_TABLE(TBL)
    ) dut (
        .apb_clk_i(apb_clk_i), .apb_reset_i(apb_reset_i), .apb_clk_en_o(apb_clk_en_o),
        .apb_addr_o(apb_addr_o), .apb_sel_o(apb_sel_o), .apb_enable_o(apb_enable_o),
        .apb_write_o(apb_write_o), .apb_strb_o(apb_strb_o), .apb_prot_o(apb_prot_o),
        .apb_wdata_o(apb_wdata_o), .apb_ready_i(apb_ready_i), .apb_rdata_i(apb_rdata_i),
        .apb_slverr_i(apb_slverr_i), .emulator_id_i(emulator_id_i),
        .done_o(done_o), .error_o(error_o)
    );

    assign all_out = {apb_clk_en_o, apb_sel_o, apb_enable_o, apb_write_o, apb_strb_o,
                      apb_prot_o, apb_addr_o, apb_wdata_o, done_o, error_o};

    // ---------------- completer config and observations ----------------
    int          wait_cfg[N];
    logic [31:0] rdata_cfg[N];
    logic        slverr_cfg[N];

    logic [31:0] obs_addr[$];
    logic        obs_write[$];
    logic [3:0]  obs_strb[$];
    logic [31:0] obs_wdata[$];
    int          obs_acc[$];
    int          obs_gap[$];
    logic        obs_err[$];
    int          proto_err, done_cyc, first_setup_c;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    function automatic cmd_t tbl_at(input int i);
        return TBL[CMD_IDX_W'(i)];
    endfunction

    function automatic logic [31:0] exp_addr(input int i);
        return tbl_at(i).addr + emulator_id_i;
    endfunction

    function automatic logic [3:0] exp_strb(input int i);
        return tbl_at(i).write ? tbl_at(i).strb : 4'd0;
    endfunction

    function automatic logic [31:0] exp_wdata(input int i);
        return tbl_at(i).write ? tbl_at(i).data : 32'd0;
    endfunction

    function automatic logic exp_timed_out(input int i);
`ifdef APB_EMU_TIMEOUT_EN
        return (wait_cfg[i] + 1 > TMO);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_acc(input int i);
        return exp_timed_out(i) ? TMO : wait_cfg[i] + 1;
    endfunction

    function automatic logic exp_err_upto(input int k);
        logic e;
        cmd_t c;
        e = 1'b0;
        for (int i = 0; i <= k; i++) begin
            c = tbl_at(i);
            if (exp_timed_out(i) || slverr_cfg[i]) e = 1'b1;
            if (!c.write && ((rdata_cfg[i] & c.mask) != (c.data & c.mask))) e = 1'b1;
        end
        return e;
    endfunction

    function automatic int exp_done_cyc();
        int s;
        s = GAP * (N - 1);
        for (int i = 0; i < N; i++) s += 1 + exp_acc(i);
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input int w0, input int w1, input int w2, input int w3, input logic match_reads);
        wait_cfg[0] = w0; wait_cfg[1] = w1; wait_cfg[2] = w2; wait_cfg[3] = w3;
        for (int i = 0; i < N; i++) begin
            slverr_cfg[i] = 1'b0;
            rdata_cfg[i]  = match_reads ? tbl_at(i).data : 32'd0;
        end
    endtask

    task automatic start_seq(input logic [31:0] id);
        @(negedge apb_clk_i);
        apb_reset_i   = 1'b1;
        apb_ready_i   = 1'b0;
        emulator_id_i = id;
        @(negedge apb_clk_i);
        @(negedge apb_clk_i);
        apb_reset_i = 1'b0;
    endtask

    // Reactive completer + monitor. Sample index 0 is the first negedge after
    // the IDLE cycle. Returns at done, at the first ACCESS sample of
    // stop_entry, or when the cycle budget runs out (done_cyc stays -1).
    task automatic run_seq(input int stop_entry, input int budget);
        logic        in_acc, in_gap, prev_setup;
        int          acc_c, gap_c, ent, e;
        logic [31:0] cur_addr, cur_wdata;
        logic        cur_write;
        logic [3:0]  cur_strb;
        obs_addr.delete(); obs_write.delete(); obs_strb.delete(); obs_wdata.delete();
        obs_acc.delete(); obs_gap.delete(); obs_err.delete();
        proto_err = 0; done_cyc = -1; first_setup_c = -1;
        in_acc = 0; in_gap = 0; prev_setup = 0; acc_c = 0; gap_c = 0; ent = -1; e = 0;
        cur_addr = '0; cur_wdata = '0; cur_write = 0; cur_strb = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge apb_clk_i);
            if (in_acc && !(apb_sel_o && apb_enable_o)) begin
                obs_addr.push_back(cur_addr);   obs_write.push_back(cur_write);
                obs_strb.push_back(cur_strb);   obs_wdata.push_back(cur_wdata);
                obs_acc.push_back(acc_c);       obs_err.push_back(error_o);
                in_acc = 0; in_gap = 1; gap_c = 0;
            end
            if (apb_prot_o !== 3'b000) proto_err++;
            if (done_o === 1'b1) begin
                if (apb_clk_en_o || apb_sel_o || apb_enable_o) proto_err++;
                done_cyc = c;
                apb_ready_i = 1'b0;
                return;
            end
            if (apb_sel_o && !apb_enable_o) begin
                if (prev_setup) proto_err++;
                if (in_gap) obs_gap.push_back(gap_c);
                in_gap = 0; prev_setup = 1; acc_c = 0;
                ent++;
                e = (ent < N) ? ent : N - 1;
                if (first_setup_c < 0) first_setup_c = c;
                cur_addr = apb_addr_o; cur_write = apb_write_o;
                cur_strb = apb_strb_o; cur_wdata = apb_wdata_o;
                if (!apb_clk_en_o) proto_err++;
                apb_ready_i = 1'b0;
            end else if (apb_sel_o && apb_enable_o) begin
                prev_setup = 0; in_acc = 1; acc_c++;
                if (apb_addr_o !== cur_addr || apb_write_o !== cur_write ||
                    apb_strb_o !== cur_strb || apb_wdata_o !== cur_wdata) proto_err++;
                if (!apb_clk_en_o) proto_err++;
                if (ent == stop_entry) return;
                if (acc_c > wait_cfg[e]) begin
                    apb_ready_i  = 1'b1;
                    apb_rdata_i  = rdata_cfg[e];
                    apb_slverr_i = slverr_cfg[e];
                end else begin
                    apb_ready_i  = 1'b0;
                    apb_rdata_i  = $urandom;
                    apb_slverr_i = 1'($urandom_range(0, 1));
                end
            end else begin
                prev_setup = 0;
                if (!apb_clk_en_o || !in_gap) proto_err++;
                if ({apb_write_o, apb_strb_o, apb_addr_o, apb_wdata_o} !== 69'd0) proto_err++;
                gap_c++;
                apb_ready_i = 1'b0;
                apb_rdata_i = $urandom;
            end
        end
        apb_ready_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apb_reset_i = 1'b1;
        repeat (3) @(negedge apb_clk_i);
        n_tests++;
        if (all_out !== 77'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h exp 0", all_out);
        end
        apb_ready_i = 1'b1; apb_slverr_i = 1'b1; apb_rdata_i = $urandom;
        @(negedge apb_clk_i);
        n_tests++;
        if (all_out !== 77'd0) begin
            n_fail++; $display("FAIL reset_inputs_ignored: got %h exp 0", all_out);
        end
        apb_ready_i = 1'b0; apb_slverr_i = 1'b0;
    endtask

    task automatic check_full(input string tag);
        n_tests++;
        if (first_setup_c !== 0) begin
            n_fail++; $display("FAIL %s_first_setup: got %0d exp 0", tag, first_setup_c);
        end
        n_tests++;
        if (obs_addr.size() !== N) begin
            n_fail++; $display("FAIL %s_count: got %0d exp %0d", tag, obs_addr.size(), N);
        end
        for (int i = 0; i < N && i < obs_addr.size(); i++) begin
            n_tests++;
            if (obs_addr[i] !== exp_addr(i) || obs_write[i] !== tbl_at(i).write ||
                obs_strb[i] !== exp_strb(i) || obs_wdata[i] !== exp_wdata(i) ||
                obs_acc[i] !== exp_acc(i) || obs_err[i] !== exp_err_upto(i)) begin
                n_fail++;
                $display("FAIL %s_xfer[%0d]: got a=%h w=%b s=%h d=%h acc=%0d err=%b exp a=%h w=%b s=%h d=%h acc=%0d err=%b",
                         tag, i, obs_addr[i], obs_write[i], obs_strb[i], obs_wdata[i], obs_acc[i], obs_err[i],
                         exp_addr(i), tbl_at(i).write, exp_strb(i), exp_wdata(i), exp_acc(i), exp_err_upto(i));
            end
        end
        for (int i = 0; i < obs_gap.size(); i++) begin
            n_tests++;
            if (obs_gap[i] !== GAP) begin
                n_fail++; $display("FAIL %s_gap[%0d]: got %0d exp %0d", tag, i, obs_gap[i], GAP);
            end
        end
        n_tests++;
        if (done_cyc !== exp_done_cyc()) begin
            n_fail++; $display("FAIL %s_done_cycle: got %0d exp %0d", tag, done_cyc, exp_done_cyc());
        end
        n_tests++;
        if (proto_err !== 0 || error_o !== exp_err_upto(N - 1)) begin
            n_fail++; $display("FAIL %s_end: proto_err=%0d error=%b exp 0/%b", tag, proto_err, error_o, exp_err_upto(N - 1));
        end
    endtask

    task automatic test_basic();
        set_cfg(0, 0, 0, 0, 1'b0);
        start_seq(32'd0);
        run_seq(-1, 200);
        check_full("basic");
        repeat (3) @(negedge apb_clk_i);
        n_tests++;
        if (done_o !== 1'b1 || apb_clk_en_o !== 1'b0 || apb_sel_o !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_hold: got done=%b clk_en=%b sel=%b exp 1/0/0", done_o, apb_clk_en_o, apb_sel_o);
        end
    endtask

    task automatic test_wait_states();
        set_cfg(0, 3, 0, 0, 1'b1);
        start_seq(32'd0);
        run_seq(-1, 200);
        n_tests++;
        if (obs_acc.size() < 2 || obs_acc[1] !== 4 || proto_err !== 0) begin
            n_fail++; $display("FAIL wait_access_len: got acc=%0d proto_err=%0d exp 4/0",
                               (obs_acc.size() > 1) ? obs_acc[1] : -1, proto_err);
        end
        n_tests++;
        if (done_cyc !== exp_done_cyc() || error_o !== 1'b0) begin
            n_fail++; $display("FAIL wait_done: got cyc=%0d err=%b exp %0d/0", done_cyc, error_o, exp_done_cyc());
        end
    endtask

    task automatic test_addr_wrap();
        set_cfg(0, 0, 0, 0, 1'b1);
        start_seq(32'hFFFF_FFF0);
        run_seq(-1, 200);
        n_tests++;
        if (obs_addr.size() < 2 || obs_addr[1] !== 32'h0000_0010) begin
            n_fail++; $display("FAIL wrap_addr: got %h exp 00000010", (obs_addr.size() > 1) ? obs_addr[1] : 32'hX);
        end
        n_tests++;
        if (obs_addr.size() < 1 || obs_addr[0] !== 32'h0000_00F0) begin
            n_fail++; $display("FAIL wrap_addr0: got %h exp 000000f0", (obs_addr.size() > 0) ? obs_addr[0] : 32'hX);
        end
    endtask

    task automatic test_read_compare();
        set_cfg(0, 0, 0, 0, 1'b1);
        rdata_cfg[2] = 32'h1234_5678;
        rdata_cfg[3] = 32'h1234_5678;
        start_seq(32'd0);
        run_seq(-1, 200);
        n_tests++;
        if (obs_err.size() < 4 || obs_err[2] !== 1'b0 || obs_err[3] !== 1'b1) begin
            n_fail++; $display("FAIL cmp_masked: got err after e2/e3 = %b/%b exp 0/1",
                               (obs_err.size() > 2) ? obs_err[2] : 1'bx, (obs_err.size() > 3) ? obs_err[3] : 1'bx);
        end
        repeat (5) @(negedge apb_clk_i);
        n_tests++;
        if (error_o !== 1'b1) begin
            n_fail++; $display("FAIL cmp_sticky: got %b exp 1", error_o);
        end
    endtask

    task automatic test_slverr();
        set_cfg(0, 0, 0, 0, 1'b1);
        slverr_cfg[0] = 1'b1;
        start_seq(32'd0);
        run_seq(-1, 200);
        n_tests++;
        if (obs_err.size() !== N || obs_err[0] !== 1'b1 || error_o !== 1'b1 || done_cyc !== exp_done_cyc()) begin
            n_fail++; $display("FAIL slverr: got n=%0d err0=%b err=%b cyc=%0d exp %0d/1/1/%0d",
                               obs_err.size(), (obs_err.size() > 0) ? obs_err[0] : 1'bx, error_o, done_cyc, N, exp_done_cyc());
        end
    endtask

    task automatic test_reset_mid();
        set_cfg(0, 0, 0, 0, 1'b1);
        start_seq(32'd0);
        run_seq(2, 200);
        // Completing response with slverr presented together with reset.
        apb_reset_i = 1'b1; apb_ready_i = 1'b1; apb_slverr_i = 1'b1; apb_rdata_i = 32'hFFFF_FFFF;
        @(negedge apb_clk_i);
        n_tests++;
        if (all_out !== 77'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h exp 0", all_out);
        end
        apb_reset_i = 1'b0; apb_ready_i = 1'b0; apb_slverr_i = 1'b0;
        run_seq(-1, 200);
        n_tests++;
        if (obs_addr.size() < 1 || obs_addr[0] !== exp_addr(0) || first_setup_c !== 0) begin
            n_fail++; $display("FAIL midreset_restart: got %h @%0d exp %h @0",
                               (obs_addr.size() > 0) ? obs_addr[0] : 32'hX, first_setup_c, exp_addr(0));
        end
        n_tests++;
        if (obs_addr.size() !== N || error_o !== 1'b0 || done_cyc !== exp_done_cyc()) begin
            n_fail++; $display("FAIL midreset_complete: got n=%0d err=%b cyc=%0d exp %0d/0/%0d",
                               obs_addr.size(), error_o, done_cyc, N, exp_done_cyc());
        end
    endtask

    task automatic test_long_wait();
        set_cfg(40, 0, 0, 0, 1'b1);
        start_seq(32'd0);
        run_seq(-1, 300);
        n_tests++;
        if (obs_acc.size() < 1 || obs_acc[0] !== exp_acc(0)) begin
            n_fail++; $display("FAIL longwait_access: got %0d exp %0d", (obs_acc.size() > 0) ? obs_acc[0] : -1, exp_acc(0));
        end
        n_tests++;
        if (error_o !== exp_err_upto(N - 1) || done_cyc !== exp_done_cyc()) begin
            n_fail++; $display("FAIL longwait_end: got err=%b cyc=%0d exp %b/%0d",
                               error_o, done_cyc, exp_err_upto(N - 1), exp_done_cyc());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++) begin
                wait_cfg[i]   = $urandom_range(0, 3);
                rdata_cfg[i]  = ($urandom_range(0, 1) == 1) ? tbl_at(i).data : $urandom;
                slverr_cfg[i] = ($urandom_range(0, 3) == 0);
            end
            start_seq($urandom);
            run_seq(-1, 200);
            check_full("random");
        end
    endtask

    initial begin
        set_cfg(0, 0, 0, 0, 1'b0);
        test_reset();
        test_basic();
        test_wait_states();
        test_addr_wrap();
        test_read_compare();
        test_slverr();
        test_reset_mid();
        test_long_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
